// File: rtl/seg_scan_driver_if.sv
// Bundle between the display selector and the 8-digit scan driver.
// The master side supplies the patterns, enables and LEDs. The slave side drives the display pins.
interface seg_scan_driver_if;
  logic [7:0] seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h;
  logic [7:0] dig_en;
  logic [7:0] led_in;
  logic [7:0] seg_out;
  logic [7:0] dig_sel;
  logic [7:0] led_out;
  logic       frame_tick;

  modport master (
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h, dig_en, led_in,
    input  seg_out, dig_sel, led_out, frame_tick
  );

  modport slave (
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h, dig_en, led_in,
    output seg_out, dig_sel, led_out, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner with a per-slot blanking interval.
// Inputs are snapshotted once per frame, so a digit never tears partway through a frame.
module seg_scan_driver #(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);
  localparam int unsigned     CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [0:0]      ST_BLANK = 1'b0;
  localparam logic [0:0]      ST_SHOW  = 1'b1;
  localparam logic [7:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]      DIG_OFF  = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][7:0] pat_q, pat_d, pat_in;
  logic [7:0]      en_q, en_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      seg_q, seg_d;
  logic [7:0]      dig_q, dig_d;
  logic            tick_q;
  logic            snap;
  logic [0:0]      state;

  assign pat_in = {bus.seg_h, bus.seg_g, bus.seg_f, bus.seg_e,
                   bus.seg_d, bus.seg_c, bus.seg_b, bus.seg_a};

  always_comb begin
    snap  = (cnt_q == '0) && (idx_q == 3'd0);
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = (cnt_q == CNT_LAST) ? idx_q + 3'd1 : idx_q;
    pat_d = snap ? pat_in     : pat_q;
    en_d  = snap ? bus.dig_en : en_q;
    led_d = snap ? bus.led_in : led_q;
    state = (int'(cnt_q) >= int'(BLANK_CYCLES)) ? ST_SHOW : ST_BLANK;
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    // Use the post-snapshot shadow, so digit 0 already shows fresh data when there is no blanking.
    if (state == ST_SHOW && en_d[idx_q]) begin
      seg_d = pat_d[idx_q] ^ SEG_OFF;
      dig_d = (8'h01 << idx_q) ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      pat_q  <= '0;
      en_q   <= 8'h00;
      led_q  <= 8'h00;
      seg_q  <= SEG_OFF;
      dig_q  <= DIG_OFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pat_q  <= pat_d;
      en_q   <= en_d;
      led_q  <= led_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      tick_q <= snap;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.led_out    = led_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances share one stimulus. One instance is active-low with blanking.
// The other is active-high with no blanking. Each cycle's expectation is queued before the edge and checked after it.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_driver_if bus0();
  seg_scan_driver_if bus1();

  logic [7:0] pat [8];
  logic [7:0] en, led;

  assign bus0.seg_a = pat[0]; assign bus0.seg_b = pat[1];
  assign bus0.seg_c = pat[2]; assign bus0.seg_d = pat[3];
  assign bus0.seg_e = pat[4]; assign bus0.seg_f = pat[5];
  assign bus0.seg_g = pat[6]; assign bus0.seg_h = pat[7];
  assign bus0.dig_en = en;    assign bus0.led_in = led;
  assign bus1.seg_a = pat[0]; assign bus1.seg_b = pat[1];
  assign bus1.seg_c = pat[2]; assign bus1.seg_d = pat[3];
  assign bus1.seg_e = pat[4]; assign bus1.seg_f = pat[5];
  assign bus1.seg_g = pat[6]; assign bus1.seg_h = pat[7];
  assign bus1.dig_en = en;    assign bus1.led_in = led;

  seg_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seg_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic [7:0] d0, s0, d1, s1, led;
    logic       ft;
  } exp_t;

  exp_t       sb[$];
  int         vecs = 0;
  int         miss = 0;
  int         j = 0;
  logic [7:0] fpat [8];
  logic [7:0] fen, fled;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s j=%0d: got %h want %h", tag, j, obs, exp);
    end
  endtask

  // One clock: the expectation is built from the spec timing (cycle j after the release edge),
  // then the DUT outputs are sampled at the following negedge.
  task automatic cyc();
    exp_t e, g;
    int k, p;
    logic on0, on1;
    logic [7:0] oh;
    e = '0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) fpat[i] = 8'h00;
      fen = 8'h00; fled = 8'h00;
      e.d0 = 8'hFF; e.s0 = 8'hFF; e.d1 = 8'h00; e.s1 = 8'h00; e.led = 8'h00; e.ft = 1'b0;
      j = 0;
    end else begin
      if (j % 64 == 0) begin
        fpat = pat; fen = en; fled = led;
      end
      k = (j / 8) % 8;
      p = j % 8;
      oh = 8'h01 << k;
      on0 = (p >= 2) && fen[k];
      on1 = fen[k];
      e.d0  = on0 ? ~oh : 8'hFF;
      e.s0  = on0 ? ~fpat[k] : 8'hFF;
      e.d1  = on1 ? oh : 8'h00;
      e.s1  = on1 ? fpat[k] : 8'h00;
      e.led = fled;
      e.ft  = (j % 64 == 0);
      j++;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sb.pop_front();
    chk("dig_sel0",  bus0.dig_sel, g.d0);
    chk("seg_out0",  bus0.seg_out, g.s0);
    chk("led_out0",  bus0.led_out, g.led);
    chk("tick0",     {7'b0, bus0.frame_tick}, {7'b0, g.ft});
    chk("dig_sel1",  bus1.dig_sel, g.d1);
    chk("seg_out1",  bus1.seg_out, g.s1);
    chk("led_out1",  bus1.led_out, g.led);
    chk("tick1",     {7'b0, bus1.frame_tick}, {7'b0, g.ft});
    chk("onehot0",   {7'b0, ($countones(~bus0.dig_sel) <= 1)}, 8'd1);
    chk("onehot1",   {7'b0, ($countones(bus1.dig_sel) <= 1)}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    en  = 8'hFF;
    led = 8'h5A;
    @(negedge clk);
    repeat (2) cyc();

    // Frame 0: full walk, all digits enabled.
    rst_n = 1'b1;
    repeat (64) cyc();

    // Change digit 2 while idx=4 of frame 1; the new pattern appears only in frame 2.
    repeat (32) cyc();
    pat[2] = 8'h7F;
    repeat (96) cyc();

    // Mask even digits mid-frame; it takes effect at the next snapshot.
    repeat (4) cyc();
    en  = 8'hAA;
    led = 8'hC3;
    repeat (124) cyc();

    // One-cycle reset at idx=5, cnt=4, then restart from a fresh snapshot.
    repeat (44) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (70) cyc();

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
